// File: rtl/router_trace_capture.sv
// router_trace_capture: DfD capture stage behind a router's trigger/trace outputs.
// Each trigger cycle while ARMED stores a time-stamped trace word in a circular
// buffer. A debug host drains the buffer through a first-word-fall-through
// valid/ready port.
// Optional build macro TRACE_DEDUP_EN folds repeats of the most recently written
// trace word into a 4-bit saturating repeat count kept alongside that entry.
module router_trace_capture #(
  parameter int DEPTH        = 16,
  parameter int TSw          = 16,
  parameter int STOP_ON_FULL = 0,
  localparam int AW          = $clog2(DEPTH),
`ifdef TRACE_DEDUP_EN
  localparam int RD_W        = TSw + 36
`else
  localparam int RD_W        = TSw + 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            arm,
  input  logic            stop,
  input  logic            trigger,
  input  logic [31:0]     trace,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [RD_W-1:0] rd_data,
  output logic [1:0]      cap_state,
  output logic [AW:0]     fill_level,
  output logic [15:0]     overflow_cnt,
  output logic            done
);

  localparam int          ENT_W    = TSw + 32;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_LVL = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    STOPPED = 2'd2
  } cap_state_e;

  cap_state_e        state_q, state_d;
  logic              arm_go;
  logic [TSw-1:0]    ts_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       fill_q, fill_d;
  logic [15:0]       ovf_q;
  logic              done_q;
  logic [ENT_W-1:0]  mem [DEPTH];

  logic              capture, full, rd_en, wr_en, drop, dup_hit;

`ifdef TRACE_DEDUP_EN
  logic [3:0]        rep_mem [DEPTH];
  logic              last_vld_q;
  logic [31:0]       last_trace_q;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
`endif

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Push/pop decisions; fullness is judged before any same-cycle pop.
  always_comb begin
    capture = (state_q == ARMED) && trigger;
    full    = (fill_q == FULL_LVL);
    rd_en   = (fill_q != '0) && rd_ready;
`ifdef TRACE_DEDUP_EN
    // The newest entry is still resident unless the buffer is empty or it leaves this cycle.
    dup_hit = capture && last_vld_q && (trace == last_trace_q) &&
              (fill_q != '0) && !((fill_q == ONE_LVL) && rd_en);
`else
    dup_hit = 1'b0;
`endif
    wr_en   = capture && !full && !dup_hit;
    drop    = capture && full && !dup_hit;
    fill_d  = fill_q;
    if (wr_en && !rd_en)      fill_d = fill_q + ONE_LVL;
    else if (!wr_en && rd_en) fill_d = fill_q - ONE_LVL;
  end

  // Capture state machine: next state; stop always beats a same-cycle arm.
  always_comb begin
    state_d = state_q;
    arm_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm && !stop) begin
          state_d = ARMED;
          arm_go  = 1'b1;
        end
      end
      ARMED: begin
        if (stop)
          state_d = STOPPED;
        else if ((STOP_ON_FULL != 0) && wr_en && !rd_en && (fill_q == LAST_LVL))
          state_d = STOPPED;
      end
      STOPPED: begin
        if (arm && !stop) begin
          state_d = ARMED;
          arm_go  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, timestamp, pointers, fill, overflow and done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + 1'b1;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      fill_q  <= fill_d;
      if (arm_go)    ovf_q <= '0;
      else if (drop) ovf_q <= sat_inc16(ovf_q);
      done_q  <= (state_d == STOPPED) && (fill_d == '0);
    end
  end

  // Buffer storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {ts_q, trace};
  end

`ifdef TRACE_DEDUP_EN
  // Tracks whether a word has been written since the last arm.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last_vld_q <= 1'b0;
    else if (arm_go) last_vld_q <= 1'b0;
    else if (wr_en)  last_vld_q <= 1'b1;
  end

  // Most recently written trace word, compared against each new capture.
  always_ff @(posedge clk) begin
    if (wr_en) last_trace_q <= trace;
  end

  // Repeat counts: cleared on a fresh write, bumped in place on a repeat.
  always_ff @(posedge clk) begin
    if (wr_en)        rep_mem[wr_ptr_q] <= 4'd0;
    else if (dup_hit) rep_mem[wr_ptr_q - 1'b1] <= sat_inc4(rep_mem[wr_ptr_q - 1'b1]);
  end

  assign rd_data = rd_valid ? {rep_mem[rd_ptr_q], mem[rd_ptr_q]} : '0;
`else
  assign rd_data = rd_valid ? mem[rd_ptr_q] : '0;
`endif

  assign rd_valid     = (fill_q != '0);
  assign cap_state    = state_q;
  assign fill_level   = fill_q;
  assign overflow_cnt = ovf_q;
  assign done         = done_q;

endmodule
